// File: rtl/zpu_wb_pkg.sv
// Shared definitions for zpu Wishbone slaves: register indices, CTRL bit
// positions, the decoded request bundle and byte-lane merging.
package zpu_wb_pkg;

    // Word index of each register (byte offset / 4)
    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_PRESCALE = 3'd1;
    localparam logic [2:0] REG_LOAD     = 3'd2;
    localparam logic [2:0] REG_COUNT    = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_RELOAD = 1;
    localparam int CTRL_IRQ_EN = 2;
    localparam int CTRL_W      = 3;

    // Request presented to the register logic in the accept cycle
    typedef struct packed {
        logic        we;
        logic [2:0]  idx;
        logic [3:0]  sel;
        logic [31:0] wdata;
    } wb_req_t;

    // Replace the byte lanes of old_val selected by sel with those of new_val
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = sel[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/zpu_wb_slave_if.sv
// Pipelined Wishbone slave front end: address decode, single-cycle ack and
// registered read data. Never stalls; one request accepted per clock.
module zpu_wb_slave_if
    import zpu_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h0800_0000,
    parameter logic [31:0] ADR_MASK = 32'hFFFF_FFE0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel,
    input  logic        wb_we,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    output logic        wb_ack,
    output logic        wb_stall,
    output logic        req_valid,
    output wb_req_t     req,
    input  logic [31:0] rd_data
);

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;

    // Decode the current bus request and prepare the ack/read-data response
    always_comb begin
        req_valid = wb_cyc & wb_stb & ((wb_adr & ADR_MASK) == (BASE_ADR & ADR_MASK));
        req.we    = wb_we;
        req.idx   = wb_adr[4:2];
        req.sel   = wb_sel;
        req.wdata = wb_dat_i;
        ack_d     = req_valid;
        // Data bus idles at zero between acks and on write acks
        dat_d     = (req_valid & ~wb_we) ? rd_data : '0;
    end

    // Response registers; reset drops any ack still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q <= 1'b0;
            dat_q <= '0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
        end
    end

    assign wb_ack   = ack_q;
    assign wb_dat_o = dat_q;
    assign wb_stall = 1'b0;

endmodule

// File: rtl/zpu_wb_timer.sv
// Prescaled 32-bit down-counter timer on the zpu Wishbone bus, with one-shot
// and auto-reload modes and a level interrupt for zpu_core interrupt[0].
module zpu_wb_timer
    import zpu_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h0800_0000,
    parameter logic [31:0] ADR_MASK   = 32'hFFFF_FFE0,
    parameter int          PRESCALE_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel,
    input  logic        wb_we,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    output logic        wb_ack,
    output logic        wb_stall,
    output logic        irq
);

    logic                  req_valid;
    wb_req_t               req;
    logic [31:0]           rd_data;

    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]           load_q, load_d;
    logic [31:0]           count_q, count_d;
    logic                  pending_q, pending_d;
    logic                  irq_q, irq_d;

    logic                  tick;
    logic                  wr_en;
    logic [31:0]           wr_merged;

    zpu_wb_slave_if #(
        .BASE_ADR (BASE_ADR),
        .ADR_MASK (ADR_MASK)
    ) u_slave_if (
        .clk       (clk),
        .rst       (rst),
        .wb_adr    (wb_adr),
        .wb_dat_i  (wb_dat_i),
        .wb_dat_o  (wb_dat_o),
        .wb_sel    (wb_sel),
        .wb_we     (wb_we),
        .wb_cyc    (wb_cyc),
        .wb_stb    (wb_stb),
        .wb_ack    (wb_ack),
        .wb_stall  (wb_stall),
        .req_valid (req_valid),
        .req       (req),
        .rd_data   (rd_data)
    );

    // Current contents of the addressed register; also the base for lane merges
    always_comb begin
        rd_data = '0;
        case (req.idx)
            REG_CTRL:     rd_data = 32'(ctrl_q);
            REG_PRESCALE: rd_data = 32'(prescale_q);
            REG_LOAD:     rd_data = load_q;
            REG_COUNT:    rd_data = count_q;
            REG_STATUS:   rd_data = 32'(pending_q);
            default:      rd_data = '0;
        endcase
    end

    // Timer next state; bus writes are applied last so they win over tick effects
    always_comb begin
        tick       = ctrl_q[CTRL_EN] && (pcnt_q == prescale_q);
        wr_en      = req_valid & req.we;
        wr_merged  = merge_lanes(rd_data, req.wdata, req.sel);

        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        load_d     = load_q;
        count_d    = count_q;
        pending_d  = pending_q;
        pcnt_d     = (ctrl_q[CTRL_EN] && !tick) ? pcnt_q + PRESCALE_W'(1) : '0;
        irq_d      = pending_q & ctrl_q[CTRL_IRQ_EN];

        // W1C is evaluated before expiry so a same-cycle expiry keeps PENDING set
        if (wr_en && req.idx == REG_STATUS && req.sel[0] && req.wdata[0]) begin
            pending_d = 1'b0;
        end

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - 32'd1;
            end else begin
                pending_d = 1'b1;
                if (ctrl_q[CTRL_RELOAD]) begin
                    count_d = load_q;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end
        end

        if (wr_en) begin
            case (req.idx)
                REG_CTRL: begin
                    ctrl_d = wr_merged[CTRL_W-1:0];
                    if (!ctrl_q[CTRL_EN] && wr_merged[CTRL_EN]) begin
                        pcnt_d = '0;
                    end
                end
                REG_PRESCALE: prescale_d = wr_merged[PRESCALE_W-1:0];
                REG_LOAD: begin
                    load_d  = wr_merged;
                    count_d = wr_merged;
                end
                default: ;
            endcase
        end
    end

    // Timer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            load_q     <= '0;
            count_q    <= '0;
            pending_q  <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            load_q     <= load_d;
            count_q    <= count_d;
            pending_q  <= pending_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: doc/zpu_wb_timer.md
Name: zpu_wb_timer

Overview:
Wishbone (pipelined) slave peripheral that sits directly downstream of the zpu_core Wishbone master port. It replaces the fixed one-cycle `ackreg` responder for its address window. It provides a prescaled 32-bit down-counter with one-shot and auto-reload modes. Its interrupt output feeds zpu_core `interrupt[0]`.

Parameters:
BASE_ADR, 32'h0800_0000, base byte address of the register window.
ADR_MASK, 32'hFFFF_FFE0, address bits compared against BASE_ADR (32-byte window, 8 words).
PRESCALE_W, 16, width of the prescaler register and counter.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
wb_adr  input  32  byte address from master
wb_dat_i  input  32  write data from master (core `wb_out`)
wb_dat_o  output  32  read data to master (core `wb_in`)
wb_sel  input  4  byte enables; bit n = byte lane [8n+7:8n]
wb_we  input  1  write enable
wb_cyc  input  1  bus cycle
wb_stb  input  1  strobe
wb_ack  output  1  transfer acknowledge
wb_stall  output  1  stall; tied 0
irq  output  1  level interrupt to zpu_core `interrupt[0]`

Behaviour:
- Interface: clk only; reset is synchronous and active-high on `rst`.
- Reset values: all registers 0; wb_ack=0; wb_dat_o=0; irq=0; wb_stall=0 always.
- Decode: hit = wb_cyc & wb_stb & ((wb_adr & ADR_MASK) == (BASE_ADR & ADR_MASK)). Register index = wb_adr[4:2].
- Handshake: one request is accepted per cycle (no stall). wb_ack is registered and asserted exactly 1 cycle after each hit. Back-to-back hits produce back-to-back acks.
- Non-hits produce no ack. wb_cyc low in the cycle of the ack does not cancel that ack.
- Read: wb_dat_o is registered alongside wb_ack and shows register contents at the accept cycle. Between acks, wb_dat_o holds 0.
- Write: takes effect at the accept edge. Only lanes with wb_sel=1 are updated.
- Register map (byte offset):
  - 0x00 CTRL: [0] EN, [1] RELOAD, [2] IRQ_EN; other bits read 0.
  - 0x04 PRESCALE: [PRESCALE_W-1:0]; one tick every PRESCALE+1 clocks.
  - 0x08 LOAD: [31:0]. A write also copies the merged value into COUNT.
  - 0x0C COUNT: read-only current count; writes are ignored.
  - 0x10 STATUS: [0] PENDING. Writing 1 clears it; writing 0 has no effect.
  - 0x14–0x1C: read 0, writes ignored.
- Prescaler:
  - pcnt counts 0..PRESCALE while EN=1.
  - tick = EN & (pcnt==PRESCALE); pcnt wraps to 0 on tick.
  - pcnt is held at 0 while EN=0.
  - A write that sets EN from 0 to 1 resets pcnt to 0.
- Counter, on tick:
  - If COUNT!=0: COUNT <= COUNT-1.
  - If COUNT==0: PENDING <= 1; then if RELOAD, COUNT <= LOAD; else EN <= 0 and COUNT stays 0.
  - Expiry is therefore LOAD+1 ticks after arming.
- Simultaneous events:
  - PENDING set and a W1C clear in the same cycle: set wins.
  - LOAD write and a tick in the same cycle: the written value wins for COUNT.
  - CTRL write and a one-shot EN auto-clear in the same cycle: the written value wins.
- irq: registered, irq <= PENDING & IRQ_EN, so it lags PENDING by 1 cycle. Clearing IRQ_EN drops irq without clearing PENDING.
- Reset mid-operation: any pending ack is dropped (wb_ack=0 the next cycle), and the counter, prescaler and PENDING all clear.

Decomposition:
- Shared package zpu_wb_pkg: register offset constants (REG_CTRL, REG_PRESCALE, REG_LOAD, REG_COUNT, REG_STATUS), CTRL bit indices, and a byte-lane merge function (old, new, sel).
- One sub-module, zpu_wb_slave_if: decode, ack pipeline and read-data register. It is reusable for future slaves on the same bus. Timer logic stays in the top.

Test Plan:
- Single-cycle write then read: write LOAD=0x0000_0005 (sel=4'hF), read 0x0C -> wb_ack 1 cycle after each stb; read data 0x5.
- Byte-lane write: LOAD=0xAABBCCDD, then write 0x11223344 with sel=4'b0101 -> LOAD reads 0xAA22CC44.
- One-shot: PRESCALE=0, LOAD=3, CTRL=0x5 -> PENDING at clk 4 after the CTRL accept; irq 1 cycle later; EN reads 0; COUNT holds 0.
- Auto-reload with prescale: PRESCALE=1, LOAD=2, CTRL=0x3 -> PENDING set every 6 clocks; after W1C, PENDING reads 0 until the next expiry; irq stays 0 because IRQ_EN=0.
- Collision: a W1C of STATUS lands in the same cycle as an expiry -> PENDING reads 1. A LOAD=9 write in the tick cycle -> COUNT reads 9.
- Address and reset: a stb to BASE_ADR+0x40 -> no ack. Assert rst during an outstanding read -> wb_ack=0 the next cycle, and all registers read 0 afterwards.
